// File: rtl/query_patch_assembler.sv
// Packs PATCH_SIZE FIFO words into one query patch and writes it to the
// query-patch memory, NUM_QUERYS patches per start pulse.
module query_patch_assembler #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int NUM_QUERYS = 512,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             fifo_rempty_n,
  input  logic [DATA_WIDTH-1:0]            fifo_rdata,
  output logic                             fifo_deq,
  output logic                             qp_mem_csb0,
  output logic                             qp_mem_web0,
  output logic [ADDR_WIDTH-1:0]            qp_mem_addr0,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] qp_mem_wpatch0,
  output logic                             busy,
  output logic                             done
);

  localparam int PW = DATA_WIDTH * PATCH_SIZE;
  localparam int CW = $clog2(PATCH_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] patch_cnt_q, patch_cnt_d;
  logic [PW-1:0]         patch_q, patch_d;
  logic                  csb_q, csb_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PW-1:0]         wdata_q, wdata_d;
  logic                  last_word;
  logic                  last_patch;

  assign last_word  = (word_cnt_q == CW'(PATCH_SIZE - 1));
  assign last_patch = (patch_cnt_q == ADDR_WIDTH'(NUM_QUERYS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (fifo_rempty_n && last_word) state_d = WRITE;
      WRITE:   state_d = last_patch ? FINISH : COLLECT;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_deq = (state_q == COLLECT) && fifo_rempty_n;
    busy     = (state_q == COLLECT) || (state_q == WRITE);
    done     = (state_q == FINISH);
  end

  // Patch assembly; the write bundle includes the word dequeued this cycle
  always_comb begin
    word_cnt_d  = word_cnt_q;
    patch_cnt_d = patch_cnt_q;
    patch_d     = patch_q;
    csb_d       = 1'b1;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          word_cnt_d  = '0;
          patch_cnt_d = '0;
        end
      end
      COLLECT: begin
        if (fifo_deq) begin
          patch_d[DATA_WIDTH*word_cnt_q +: DATA_WIDTH] = fifo_rdata;
          word_cnt_d = word_cnt_q + 1'b1;
          if (last_word) begin
            word_cnt_d = '0;
            csb_d      = 1'b0;
            addr_d     = patch_cnt_q;
            wdata_d    = patch_d;
          end
        end
      end
      WRITE: begin
        if (!last_patch) patch_cnt_d = patch_cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q  <= '0;
      patch_cnt_q <= '0;
      patch_q     <= '0;
      csb_q       <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      patch_cnt_q <= patch_cnt_d;
      patch_q     <= patch_d;
      csb_q       <= csb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign qp_mem_csb0    = csb_q;
  assign qp_mem_web0    = csb_q;
  assign qp_mem_addr0   = addr_q;
  assign qp_mem_wpatch0 = wdata_q;

endmodule

// File: tb/tb_query_patch_assembler.sv
// Bench: one-patch instance driven from a vector table, four-patch
// instance checked by a scoreboard over directed and random runs.
module tb_query_patch_assembler;

  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  logic        a_start = 0, a_ne = 0;
  logic [10:0] a_d = 0;
  logic        a_deq, a_csb, a_web, a_busy, a_done;
  logic [8:0]  a_addr;
  logic [54:0] a_wp;

  logic        b_start = 0, b_ne = 0;
  logic [10:0] b_d = 0;
  logic        b_deq, b_csb, b_web, b_busy, b_done;
  logic [8:0]  b_addr;
  logic [54:0] b_wp;

  query_patch_assembler #(.NUM_QUERYS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start),
    .fifo_rempty_n(a_ne), .fifo_rdata(a_d), .fifo_deq(a_deq),
    .qp_mem_csb0(a_csb), .qp_mem_web0(a_web),
    .qp_mem_addr0(a_addr), .qp_mem_wpatch0(a_wp),
    .busy(a_busy), .done(a_done));

  query_patch_assembler #(.NUM_QUERYS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start),
    .fifo_rempty_n(b_ne), .fifo_rdata(b_d), .fifo_deq(b_deq),
    .qp_mem_csb0(b_csb), .qp_mem_web0(b_web),
    .qp_mem_addr0(b_addr), .qp_mem_wpatch0(b_wp),
    .busy(b_busy), .done(b_done));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard for the 4-patch instance
  logic [10:0] src4[$];
  int m_widx, m_deq, done_cnt, last_wr, st_cyc;
  bit pending;

  function automatic logic [54:0] pack(input int k);
    logic [54:0] p;
    p = '0;
    for (int j = 0; j < 5; j++) p[11*j +: 11] = src4[5*k+j];
    return p;
  endfunction

  task automatic begin_run();
    m_widx = 0;
    m_deq = 0;
    done_cnt = 0;
    pending = 0;
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (b_csb == 1'b0) begin
        chk("b_web", b_web, 0);
        chk("b_wr_timing", pending, 1);
        if (5*m_widx + 4 < src4.size()) begin
          chk("b_addr", b_addr, m_widx);
          chk("b_wpatch", b_wp, pack(m_widx));
        end else begin
          chk("b_extra_write", m_widx, 5*m_widx);
        end
        m_widx++;
        last_wr = cyc;
        pending = 0;
      end else if (pending) begin
        chk("b_wr_missing", b_csb, 0);
        pending = 0;
      end
      if (b_done) begin
        chk("b_done_busy", b_busy, 0);
        chk("b_done_gap", cyc - last_wr, 1);
        chk("b_done_widx", m_widx, 4);
        done_cnt++;
      end
      if (b_deq) begin
        chk("b_deq_nonempty", b_ne, 1);
        m_deq++;
        if (m_deq % 5 == 0) pending = 1;
      end
    end
  end

  task automatic run4(input int gap, input int restart_at, input int stop_wr);
    int idx, t;
    bit fin;
    idx = 0;
    t = 0;
    fin = 0;
    begin_run();
    @(posedge clk); #1;
    b_start = 1;
    b_ne = 0;
    st_cyc = cyc;
    while (!fin) begin
      @(posedge clk); #1;
      t++;
      b_start = (t == restart_at);
      b_ne = (idx < src4.size()) && ($urandom_range(99) >= gap);
      b_d = b_ne ? src4[idx] : 11'($urandom);
      @(negedge clk); #1;
      if (b_deq) idx++;
      if (done_cnt > 0 || (stop_wr > 0 && m_widx >= stop_wr)) fin = 1;
      if (t > 3000) begin
        chk("b_run_timeout", t, 0);
        fin = 1;
      end
    end
    @(posedge clk); #1;
    b_start = 0;
    b_ne = 0;
    repeat (3) @(posedge clk);
  endtask

  // ---------------- vector table for the 1-patch instance
  typedef struct {
    logic st, ne;
    logic [10:0] d;
    logic deq, csb, busy, done;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic st, ne, input logic [10:0] d,
                     input logic deq, csb, busy, done);
    vec_t v;
    v.st = st; v.ne = ne; v.d = d;
    v.deq = deq; v.csb = csb; v.busy = busy; v.done = done;
    tv.push_back(v);
  endtask

  task automatic reset_all();
    rst_n = 0;
    chk("rst_b_deq", b_deq, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  logic [54:0] exp1;
  int n3;

  initial begin
    exp1 = {11'd5, 11'd4, 11'd3, 11'd2, 11'd1};

    add(1, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) add(0, 1, 11'(i), 1, 1, 1, 0);
    add(0, 1, 9, 0, 0, 1, 0);
    add(0, 1, 9, 0, 1, 0, 1);
    add(0, 1, 9, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      add(0, 1, 11'(i), 1, 1, 1, 0);
      if (i < 5) repeat (3) add(0, 0, 11'h7ff, 0, 1, 1, 0);
    end
    add(0, 1, 9, 0, 0, 1, 0);
    add(0, 1, 9, 0, 1, 0, 1);
    add(0, 0, 9, 0, 1, 0, 0);

    #12;
    chk("rst_a_csb", a_csb, 1);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_b_outs", {b_deq, b_csb, b_web, b_busy, b_done}, 5'b01100);
    chk("rst_b_addr", b_addr, 0);
    chk("rst_b_wp", b_wp, 0);
    @(negedge clk);
    rst_n = 1;

    foreach (tv[i]) begin
      @(posedge clk); #1;
      a_start = tv[i].st;
      a_ne = tv[i].ne;
      a_d = tv[i].d;
      @(negedge clk);
      chk($sformatf("a_deq[%0d]", i), a_deq, tv[i].deq);
      chk($sformatf("a_csb[%0d]", i), a_csb, tv[i].csb);
      chk($sformatf("a_web[%0d]", i), a_web, tv[i].csb);
      chk($sformatf("a_busy[%0d]", i), a_busy, tv[i].busy);
      chk($sformatf("a_done[%0d]", i), a_done, tv[i].done);
      if (!tv[i].csb) begin
        chk($sformatf("a_addr[%0d]", i), a_addr, 0);
        chk($sformatf("a_wp[%0d]", i), a_wp, exp1);
      end
    end
    a_start = 0;
    a_ne = 0;

    // full run, words 0..19 back-to-back
    src4.delete();
    for (int i = 0; i < 20; i++) src4.push_back(11'(i));
    run4(0, 0, 0);
    chk("full_done_cnt", done_cnt, 1);
    chk("full_writes", m_widx, 4);
    chk("full_latency", last_wr - st_cyc, 24);
    chk("full_idle_busy", b_busy, 0);

    // second start during patch 2 must be ignored
    src4.delete();
    for (int i = 0; i < 20; i++) src4.push_back(11'(100 + 7*i));
    run4(0, 14, 0);
    chk("restart_done_cnt", done_cnt, 1);
    chk("restart_writes", m_widx, 4);

    // reset after 3 of 5 words
    src4.delete();
    for (int i = 0; i < 5; i++) src4.push_back(11'(600 + i));
    begin_run();
    @(posedge clk); #1;
    b_start = 1;
    n3 = 0;
    for (int t = 0; t < 50 && n3 < 3; t++) begin
      @(posedge clk); #1;
      b_start = 0;
      b_ne = 1;
      b_d = src4[n3];
      @(negedge clk); #1;
      if (b_deq) n3++;
    end
    chk("rst_mid_words", n3, 3);
    rst_n = 0;
    #1;
    chk("rst_mid_outs", {b_deq, b_csb, b_web, b_busy, b_done}, 5'b01100);
    chk("rst_mid_addr", b_addr, 0);
    chk("rst_mid_wp", b_wp, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_nowrite", b_csb, 1);
    end
    b_ne = 0;
    rst_n = 1;
    src4.delete();
    for (int i = 0; i < 5; i++) src4.push_back(11'(1500 + 3*i));
    run4(0, 0, 1);
    chk("rst_fresh_writes", m_widx, 1);
    reset_all();

    // idle immunity
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      b_ne = 1;
      b_d = 11'($urandom);
      @(negedge clk);
      chk("idle_b", {b_deq, b_csb, b_busy}, 3'b010);
    end
    b_ne = 0;

    // random runs with random gaps and data
    for (int r = 0; r < 6; r++) begin
      src4.delete();
      for (int i = 0; i < 20; i++) src4.push_back(11'($urandom));
      run4($urandom_range(70), $urandom_range(40), 0);
      chk("rand_done_cnt", done_cnt, 1);
      chk("rand_writes", m_widx, 4);
      repeat ($urandom_range(5)) begin
        @(posedge clk); #1;
        b_ne = 1'($urandom);
        b_d = 11'($urandom);
      end
      b_ne = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
